// File: rtl/sap_cpu_param.sv
`timescale 1ns/1ps
// Parameterised SAP-style accumulator CPU: FETCH then EX1 (plus EX2 for ADD/SUB), so 2 or 3 cycles per instruction.
// No backpressure: out_valid is a one-cycle pulse; program writes are accepted only while halted.
module sap_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              cf,
    output logic              zf,
    output logic              halted,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] breg;
    logic [DATA_W-1:0] ir;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   alu_sum;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];
    assign halted  = (state == S_IDLE) || (state == S_HALT);
    assign busy    = (state == S_FETCH) || (state == S_EX1) || (state == S_EX2);

    // SUB is A + ~B + 1 so the carry out reads as "no borrow" (A >= B).
    always_comb begin
        alu_sum = {1'b0, acc} + {1'b0, breg};
        if (opcode == OP_SUB) begin
            alu_sum = {1'b0, acc} + {1'b0, ~breg} + (DATA_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_EX1;
            S_EX1: begin
                case (opcode)
                    OP_ADD, OP_SUB: state_nxt = S_EX2;
                    OP_HLT:         state_nxt = S_HALT;
                    default:        state_nxt = S_FETCH;
                endcase
            end
            S_EX2:   state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            acc       <= '0;
            breg      <= '0;
            ir        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cf        <= 1'b0;
            zf        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (run) pc <= '0;
                end
                S_FETCH: begin
                    ir <= mem[pc];
                    pc <= pc + ADDR_W'(1);
                end
                S_EX1: begin
                    case (opcode)
                        OP_LDA:         acc  <= mem[operand];
                        OP_ADD, OP_SUB: breg <= mem[operand];
                        OP_LDI:         acc  <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                        OP_JMP:         pc   <= operand;
                        OP_JC:          if (cf) pc <= operand;
                        OP_JZ:          if (zf) pc <= operand;
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX2: begin
                    acc <= alu_sum[DATA_W-1:0];
                    cf  <= alu_sum[DATA_W];
                    zf  <= (alu_sum[DATA_W-1:0] == '0);
                end
                default: ;
            endcase
        end
    end

    // Program memory survives reset; host and STA writes can never coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (halted && prog_we) begin
                mem[prog_addr] <= prog_data;
            end else if ((state == S_EX1) && (opcode == OP_STA)) begin
                mem[operand] <= acc;
            end
        end
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
`timescale 1ns/1ps
// Directed self-checking bench for sap_cpu_param with DATA_W=8, ADDR_W=4.
module tb_sap_cpu_param;

    logic       clk;
    logic       rst;
    logic       run;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] pc;
    logic       cf;
    logic       zf;
    logic       halted;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pc        (pc),
        .cf        (cf),
        .zf        (zf),
        .halted    (halted),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (halted) break;
            step(1);
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int pulses;
        int first_k;
        logic [7:0] first_data;

        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        step(2);
        rst = 1'b0;
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {30'd0, cf, zf}, 32'd0);

        // LDA 14; ADD 15; OUT; HLT with 28 + 14
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'd28); load(4'd15, 8'd14);
        start();
        check("run_busy", 32'(busy), 32'd1);
        pulses = 0; first_k = 0; first_data = '0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (out_valid) begin
                if (pulses == 0) begin
                    first_k    = k;
                    first_data = out_data;
                end
                pulses++;
            end
        end
        check("add_pulse_count", 32'(pulses), 32'd1);
        check("add_pulse_cycle", 32'(first_k), 32'd7);
        check("add_out_data", 32'(first_data), 32'd42);
        check("add_halted", 32'(halted), 32'd1);
        check("add_flags", {30'd0, cf, zf}, 32'd0);
        check("add_pc", 32'(pc), 32'd4);

        // LDI 5; SUB 13 (=5); JZ 9; HLT at 9
        load(4'd0, 8'h55); load(4'd1, 8'h3D); load(4'd2, 8'h89);
        load(4'd9, 8'hF0); load(4'd13, 8'h05);
        start();
        step(5);
        check("sub_eq_acc", 32'(dut.acc), 32'd0);
        check("sub_eq_flags", {30'd0, cf, zf}, 32'd3);
        step(2);
        check("jz_taken_pc", 32'(pc), 32'd9);
        wait_halt("sub_eq_halt");
        check("sub_eq_final_pc", 32'(pc), 32'd10);

        // LDI 3; SUB 12 (=4); JC 0 not taken; HLT
        load(4'd0, 8'h53); load(4'd1, 8'h3C); load(4'd2, 8'h70);
        load(4'd3, 8'hF0); load(4'd12, 8'h04);
        start();
        step(2);
        check("ldi_keeps_flags", {30'd0, cf, zf}, 32'd3);
        check("ldi_acc", 32'(dut.acc), 32'd3);
        step(3);
        check("sub_lt_acc", 32'(dut.acc), 32'hFF);
        check("sub_lt_flags", {30'd0, cf, zf}, 32'd0);
        step(2);
        check("jc_not_taken_pc", 32'(pc), 32'd3);
        wait_halt("sub_lt_halt");
        check("sub_lt_final_pc", 32'(pc), 32'd4);

        // JMP 10; LDA 14 (HLT word); STA 0; JMP 15; NOP at 15 wraps to patched mem[0]
        load(4'd0, 8'h6A); load(4'd10, 8'h1E); load(4'd11, 8'h40);
        load(4'd12, 8'h6F); load(4'd14, 8'hF0); load(4'd15, 8'h00);
        start();
        step(9);
        check("wrap_pc", 32'(pc), 32'd0);
        check("sta_mem0", 32'(dut.mem[0]), 32'hF0);
        step(3);
        check("wrap_halted", 32'(halted), 32'd1);
        check("wrap_final_pc", 32'(pc), 32'd1);

        // LDI 7; ADD 13 (=5); HLT -- reset lands in EX2
        load(4'd0, 8'h57); load(4'd1, 8'h2D); load(4'd2, 8'hF0); load(4'd13, 8'h05);
        start();
        step(4);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_acc", 32'(dut.acc), 32'd7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("ex2_rst_halted", 32'(halted), 32'd1);
        check("ex2_rst_busy", 32'(busy), 32'd0);
        check("ex2_rst_acc", 32'(dut.acc), 32'd0);
        check("ex2_rst_flags", {30'd0, cf, zf}, 32'd0);
        check("ex2_rst_pc", 32'(pc), 32'd0);
        check("ex2_rst_mem13", 32'(dut.mem[13]), 32'd5);
        check("ex2_rst_mem1", 32'(dut.mem[1]), 32'h2D);

        // rst overrides run and prog_we in the same cycle
        load(4'd5, 8'h11);
        rst = 1'b1; run = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'h99;
        step(1);
        rst = 1'b0; run = 1'b0; prog_we = 1'b0;
        check("rst_blocks_write", 32'(dut.mem[5]), 32'h11);
        check("rst_blocks_run", 32'(halted), 32'd1);

        // prog_we and run held while busy are ignored
        start();
        run = 1'b1; prog_we = 1'b1; prog_addr = 4'd13; prog_data = 8'h77;
        step(5);
        run = 1'b0; prog_we = 1'b0;
        check("busy_run_ignored_pc", 32'(pc), 32'd2);
        check("busy_write_ignored", 32'(dut.mem[13]), 32'd5);
        wait_halt("busy_halt");
        check("busy_add_acc", 32'(dut.acc), 32'd12);
        check("busy_final_pc", 32'(pc), 32'd3);

        // write and run in the same halted cycle: first fetch sees new word
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h59; run = 1'b1;
        step(1);
        prog_we = 1'b0; run = 1'b0;
        check("wr_run_mem0", 32'(dut.mem[0]), 32'h59);
        step(2);
        check("wr_run_ldi_acc", 32'(dut.acc), 32'd9);
        wait_halt("wr_run_halt");
        check("wr_run_add_acc", 32'(dut.acc), 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
